base_ram_arbiter: RTL and testbench
===================================

BASE_RAM_ARBITER -- requirements
Module: base_ram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge; all state changes on it), rst input 1 (synchronous, active-high).
REQ-002 The block SHALL have these parameters: ADDR_W, 20, SRAM word-address width; WAIT, 1, extra SRAM access cycles (0..15).
REQ-003 The block SHALL have these instruction-fetch port signals: if_req input 1; if_addr input 32 (byte address); if_ack output 1; if_rdata output 32.
REQ-004 The block SHALL have these data port signals: mem_req input 1; mem_we input 1; mem_addr input 32; mem_sel input 4 (byte enables, active-high); mem_wdata input 32; mem_ack output 1; mem_rdata output 32.
REQ-005 The block SHALL have these SRAM-side signals: ram_addr output ADDR_W; ram_be_n output 4; ram_ce_n output 1; ram_oe_n output 1; ram_we_n output 1; ram_dout output 32; ram_dout_en output 1 (top-level tristate enable); ram_din input 32.

Function
REQ-006 The SRAM word address SHALL be the granted address bits [ADDR_W+1:2]; bits [1:0] SHALL be ignored.
REQ-007 The FSM SHALL have the states IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD and ACK.
REQ-008 In IDLE with any request pending, the FSM SHALL grant one requester and register its address, sel, wdata, we and port identity on that edge; READ or WR_SETUP SHALL follow.
REQ-009 The default arbitration SHALL be fixed priority: mem_req wins over if_req when both are high in the same IDLE cycle.
REQ-010 An IF grant SHALL always be a read, with ram_be_n = 4'h0.
REQ-011 READ SHALL last WAIT+1 cycles with ram_ce_n=0 and ram_oe_n=0; ram_din SHALL be captured into the granted port's rdata register on the last READ cycle, then the FSM SHALL go to ACK.
REQ-012 A write SHALL pass through three phases: WR_SETUP for 1 cycle (ce_n=0, we_n=1, dout_en=1); WR_PULSE for WAIT+1 cycles (we_n=0); WR_HOLD for 1 cycle (we_n=1, dout_en=1); then ACK. ram_oe_n SHALL stay 1 throughout.
REQ-013 ACK SHALL last 1 cycle: the granted port's ack=1 and all SRAM strobes inactive; the FSM SHALL then return to IDLE. No grant SHALL occur in ACK.
REQ-014 Read latency from the req-sampled edge (cycle 0) SHALL be: ack in cycle WAIT+2. Write latency SHALL be: ack in cycle WAIT+4.
REQ-015 if_rdata and mem_rdata SHALL hold their value until the next read on that same port completes.
REQ-016 A requester SHALL hold req and its operands stable until ack. If req drops mid-transaction, the transaction SHALL still complete and ack SHALL still pulse. A req still high in the cycle after ack SHALL be treated as a new request.
REQ-017 All SRAM-side outputs SHALL be decoded from registered state only, with no combinational path from req inputs to RAM pins.
REQ-018 In IDLE and ACK the outputs SHALL be: ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_be_n=4'hF, ram_dout_en=0. ram_addr SHALL hold its last value.
REQ-019 ram_dout_en and ram_oe_n=0 SHALL never be asserted in the same cycle.

Reset
REQ-020 When rst=1 at a clk edge, the block SHALL enter IDLE, including mid-transaction. No ack SHALL be issued for an aborted access.
REQ-021 After reset: if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, ram_addr=0, ram_dout=0, strobes inactive as in REQ-018, round-robin pointer = mem.

Configuration
REQ-022 The macro BASE_RAM_ARB_RR_EN SHALL select round-robin arbitration: when both ports request in IDLE, the port not granted last SHALL win, and the pointer SHALL update on each grant.
REQ-023 Without BASE_RAM_ARB_RR_EN, arbitration SHALL be the fixed mem-first priority of REQ-009 and no pointer register SHALL exist.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the port-ID constants (PORT_IF, PORT_MEM) and the default WAIT/ADDR_W constants.
REQ-025 The block SHALL be a single module with no sub-module; the tristate buffer SHALL stay at top level.

Verification
REQ-026 With WAIT=1, an IF read of addr 0x00000010 with ram_din=0xDEADBEEF SHALL give ram_addr=0x4, oe_n low in cycles 1-2, if_ack in cycle 3, if_rdata=0xDEADBEEF.
REQ-027 With WAIT=1, a mem write of addr 0x20, sel 4'b0011, wdata 0x12345678 SHALL give ram_addr=0x8, be_n=4'b1100, we_n low in cycles 2-3 only, dout_en in cycles 1-4, mem_ack in cycle 5.
REQ-028 With if_req and mem_req raised in the same cycle, fixed mode SHALL serve mem then IF (if_ack after mem_ack+1+latency). In RR mode, continuous dual requests SHALL alternate grants mem, IF, mem, IF.
REQ-029 rst asserted during WR_PULSE SHALL force we_n=1 and ce_n=1 on the next edge, with no mem_ack; a request after reset SHALL complete normally.
REQ-030 With WAIT=0, back-to-back IF reads SHALL each ack 2 cycles after grant with one IDLE cycle between them; a protocol checker SHALL confirm dout_en and oe_n=0 never overlap.

Source files
------------

// File: rtl/base_ram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding, port IDs and
// default geometry/timing.
package base_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        ACK      = 3'd5
    } state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    localparam int DEFAULT_WAIT   = 1;
    localparam int DEFAULT_ADDR_W = 20;

endpackage

// File: rtl/base_ram_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one asynchronous SRAM.
// Define BASE_RAM_ARB_RR_EN for round-robin arbitration; default is fixed mem-first.
module base_ram_arbiter
    import base_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int WAIT   = DEFAULT_WAIT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_dout,
    output logic              ram_dout_en,
    input  logic [31:0]       ram_din
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic              last_cycle;
    logic              grant;
    logic              pick;
    logic              port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       dout_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    // Byte-offset and upper address bits never reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign last_cycle = (cnt == 4'd0);

`ifdef BASE_RAM_ARB_RR_EN
    // Port that wins the next simultaneous request.
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= PORT_MEM;
        end else if (grant) begin
            rr_ptr <= ~pick;
        end
    end

    always_comb begin
        pick = mem_req ? PORT_MEM : PORT_IF;
        if (mem_req && if_req) begin
            pick = rr_ptr;
        end
    end
`else
    always_comb begin
        pick = mem_req ? PORT_MEM : PORT_IF;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req || if_req) begin
                    grant      = 1'b1;
                    next_state = (pick == PORT_MEM && mem_we) ? WR_SETUP : READ;
                end
            end
            READ:     if (last_cycle) next_state = ACK;
            WR_SETUP: next_state = WR_PULSE;
            WR_PULSE: if (last_cycle) next_state = WR_HOLD;
            WR_HOLD:  next_state = ACK;
            ACK:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // One counter times both the READ and the WR_PULSE phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant) begin
            cnt <= WAIT_CNT;
        end else if ((state == READ || state == WR_PULSE) && !last_cycle) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q      <= PORT_MEM;
            addr_q      <= '0;
            be_q        <= 4'hF;
            dout_q      <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (grant) begin
                port_q <= pick;
                if (pick == PORT_MEM) begin
                    addr_q <= mem_addr[ADDR_W+1:2];
                    be_q   <= ~mem_sel;
                    dout_q <= mem_wdata;
                end else begin
                    addr_q <= if_addr[ADDR_W+1:2];
                    be_q   <= 4'h0;
                end
            end
            if (state == READ && last_cycle) begin
                if (port_q == PORT_MEM) begin
                    mem_rdata_q <= ram_din;
                end else begin
                    if_rdata_q <= ram_din;
                end
            end
        end
    end

    // SRAM strobes depend only on registered state, never on the req inputs.
    always_comb begin
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_be_n    = 4'hF;
        ram_dout_en = 1'b0;
        case (state)
            READ: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                ram_be_n = be_q;
            end
            WR_SETUP, WR_HOLD: begin
                ram_ce_n    = 1'b0;
                ram_be_n    = be_q;
                ram_dout_en = 1'b1;
            end
            WR_PULSE: begin
                ram_ce_n    = 1'b0;
                ram_we_n    = 1'b0;
                ram_be_n    = be_q;
                ram_dout_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_dout  = dout_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = (state == ACK) && (port_q == PORT_IF);
    assign mem_ack   = (state == ACK) && (port_q == PORT_MEM);

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Self-checking bench for base_ram_arbiter: WAIT=1 instance for the main vectors
// and corner sequences, WAIT=0 instance for back-to-back fetches.
module tb_base_ram_arbiter;
    import base_ram_arbiter_pkg::*;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] din;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        int          exp_lat;
        logic [15:0] exp_oe;
        logic [15:0] exp_we;
        logic [15:0] exp_den;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- WAIT=1 instance ----------------
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_din = '0;
    logic [3:0]  mem_sel = '0;
    logic        if_ack, mem_ack, ram_ce_n, ram_oe_n, ram_we_n, ram_dout_en;
    logic [31:0] if_rdata, mem_rdata, ram_dout;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;

    base_ram_arbiter #(.ADDR_W(20), .WAIT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_dout(ram_dout),
        .ram_dout_en(ram_dout_en), .ram_din(ram_din)
    );

    // ---------------- WAIT=0 instance ----------------
    logic        z_if_req = 1'b0, z_mem_req = 1'b0, z_mem_we = 1'b0;
    logic [31:0] z_if_addr = '0, z_mem_addr = '0, z_mem_wdata = '0, z_ram_din = '0;
    logic [3:0]  z_mem_sel = '0;
    logic        z_if_ack, z_mem_ack, z_ram_ce_n, z_ram_oe_n, z_ram_we_n, z_ram_dout_en;
    logic [31:0] z_if_rdata, z_mem_rdata, z_ram_dout;
    logic [19:0] z_ram_addr;
    logic [3:0]  z_ram_be_n;

    base_ram_arbiter #(.ADDR_W(20), .WAIT(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
        .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_sel(z_mem_sel),
        .mem_wdata(z_mem_wdata), .mem_ack(z_mem_ack), .mem_rdata(z_mem_rdata),
        .ram_addr(z_ram_addr), .ram_be_n(z_ram_be_n), .ram_ce_n(z_ram_ce_n),
        .ram_oe_n(z_ram_oe_n), .ram_we_n(z_ram_we_n), .ram_dout(z_ram_dout),
        .ram_dout_en(z_ram_dout_en), .ram_din(z_ram_din)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_if  = '0;
    logic [31:0] last_mem = '0;
    vec_t        vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] e;
        e = 32'hBAD0BAD0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    // Bus must never drive while the SRAM drives.
    always @(negedge clk) begin
        if (!rst) begin
            check("overlap_w1", {31'b0, ram_dout_en & ~ram_oe_n}, 32'd0);
            check("overlap_w0", {31'b0, z_ram_dout_en & ~z_ram_oe_n}, 32'd0);
        end
    end

    // One transaction on the WAIT=1 instance; returns at the negedge of its ack cycle.
    task automatic run_txn(input string tag, input vec_t v);
        logic [15:0] oe_m, we_m, den_m;
        logic [31:0] dout_seen;
        int          lat;
        oe_m = '0; we_m = '0; den_m = '0; dout_seen = '0; lat = -1;
        @(negedge clk);
        ram_din = v.din;
        if (v.port == PORT_MEM) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
            mem_sel = v.sel; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        if (!v.we) exp_q.push_back(v.din);
        @(posedge clk);
        for (int k = 1; k < 16 && lat < 0; k++) begin
            @(negedge clk);
            oe_m[k]  = ~ram_oe_n;
            we_m[k]  = ~ram_we_n;
            den_m[k] = ram_dout_en;
            if (k == 1) begin
                check({tag, "_addr"}, {12'b0, ram_addr}, {12'b0, v.exp_addr});
                check({tag, "_be_n"}, {28'b0, ram_be_n}, {28'b0, v.exp_be_n});
            end
            if (k == 2) dout_seen = ram_dout;
            if (if_ack || mem_ack) begin
                lat = k;
                if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
                check({tag, "_ack_port"}, {30'b0, if_ack, mem_ack},
                      (v.port == PORT_MEM) ? 32'd1 : 32'd2);
                if (!v.we) begin
                    if (v.port == PORT_MEM) begin
                        last_mem = pop_exp();
                        check({tag, "_mem_rdata"}, mem_rdata, last_mem);
                        check({tag, "_if_hold"}, if_rdata, last_if);
                    end else begin
                        last_if = pop_exp();
                        check({tag, "_if_rdata"}, if_rdata, last_if);
                        check({tag, "_mem_hold"}, mem_rdata, last_mem);
                    end
                end else begin
                    check({tag, "_dout"}, dout_seen, v.wdata);
                    check({tag, "_if_hold"}, if_rdata, last_if);
                    check({tag, "_mem_hold"}, mem_rdata, last_mem);
                end
            end
        end
        if (lat < 0) begin
            if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
            if (!v.we) void'(pop_exp());
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_oe_mask"}, {16'b0, oe_m}, {16'b0, v.exp_oe});
        check({tag, "_we_mask"}, {16'b0, we_m}, {16'b0, v.exp_we});
        check({tag, "_den_mask"}, {16'b0, den_m}, {16'b0, v.exp_den});
    endtask

    initial begin
        vec_t v;
        int   mem_lat, if_lat, ack_cnt;
        int   z_ack_q[$];

        //          port      we    addr          sel     wdata         din           addr     be_n  lat oe      we      den
        vecs[0] = '{PORT_IF,  1'b0, 32'h00000010, 4'h0,   32'h0,        32'hDEADBEEF, 20'h4,   4'h0, 3, 16'h6, 16'h0, 16'h0};
        vecs[1] = '{PORT_MEM, 1'b1, 32'h00000020, 4'b0011, 32'h12345678, 32'h0,       20'h8,   4'hC, 5, 16'h0, 16'hC, 16'h1E};
        vecs[2] = '{PORT_MEM, 1'b0, 32'h12345678, 4'hF,   32'h0,        32'hA5A50F0F, 20'hD159E, 4'h0, 3, 16'h6, 16'h0, 16'h0};
        vecs[3] = '{PORT_IF,  1'b0, 32'hFFFFFFFF, 4'h0,   32'h0,        32'h0BADF00D, 20'hFFFFF, 4'h0, 3, 16'h6, 16'h0, 16'h0};
        vecs[4] = '{PORT_MEM, 1'b1, 32'h00000003, 4'b1000, 32'hCAFEBABE, 32'h0,       20'h0,   4'h7, 5, 16'h0, 16'hC, 16'h1E};
        vecs[5] = '{PORT_MEM, 1'b0, 32'h00000044, 4'b0100, 32'h0,       32'h11223344, 20'h11,  4'hB, 3, 16'h6, 16'h0, 16'h0};
        vecs[6] = '{PORT_IF,  1'b0, 32'h00000100, 4'h0,   32'h0,        32'h55AA55AA, 20'h40,  4'h0, 3, 16'h6, 16'h0, 16'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_acks", {30'b0, if_ack, mem_ack}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_addr", {12'b0, ram_addr}, 32'd0);
        check("rst_ram_dout", ram_dout, 32'd0);
        check("rst_strobes", {27'b0, ram_ce_n, ram_oe_n, ram_we_n, ram_dout_en, 1'b0}, 32'b11100);
        check("rst_be_n", {28'b0, ram_be_n}, 32'hF);

        for (int i = 0; i < 7; i++) run_txn($sformatf("v%0d", i), vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v.port     = logic'($urandom_range(0, 1));
            v.we       = (v.port == PORT_MEM) ? logic'($urandom_range(0, 1)) : 1'b0;
            v.addr     = $urandom();
            v.sel      = 4'($urandom_range(1, 15));
            v.wdata    = $urandom();
            v.din      = $urandom();
            v.exp_addr = v.addr[21:2];
            v.exp_be_n = (v.port == PORT_IF) ? 4'h0 : ~v.sel;
            v.exp_lat  = v.we ? 5 : 3;
            v.exp_oe   = v.we ? 16'h0 : 16'h6;
            v.exp_we   = v.we ? 16'hC : 16'h0;
            v.exp_den  = v.we ? 16'h1E : 16'h0;
            run_txn($sformatf("r%0d", i), v);
        end

        // simultaneous requests: mem first, then IF after ACK + IDLE
        @(negedge clk);
        @(negedge clk);
        ram_din = 32'h600DCAFE;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8; mem_sel = 4'hF;
        if_req = 1'b1; if_addr = 32'hC;
        exp_q.push_back(32'h600DCAFE);
        exp_q.push_back(32'h0F00D123);
        mem_lat = -1; if_lat = -1;
        @(posedge clk);
        for (int k = 1; k < 20 && (mem_lat < 0 || if_lat < 0); k++) begin
            @(negedge clk);
            if (mem_ack) begin
                mem_lat = k; mem_req = 1'b0;
                last_mem = pop_exp();
                check("dual_mem_rdata", mem_rdata, last_mem);
                ram_din = 32'h0F00D123;
            end
            if (if_ack) begin
                if_lat = k; if_req = 1'b0;
                last_if = pop_exp();
                check("dual_if_rdata", if_rdata, last_if);
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
        check("dual_mem_lat", 32'(mem_lat), 32'd3);
        check("dual_if_lat", 32'(if_lat), 32'd7);

        // reset during WR_PULSE aborts the write without an ack
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h24; mem_sel = 4'hF; mem_wdata = 32'h0F0F0F0F;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_pulse", {31'b0, ram_we_n}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_strobes", {30'b0, ram_we_n, ram_ce_n}, 32'd3);
        check("abort_ack", {31'b0, mem_ack}, 32'd0);
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_ack || if_ack) ack_cnt++;
        end
        check("abort_no_ack", 32'(ack_cnt), 32'd0);
        check("abort_mem_rdata", mem_rdata, 32'd0);
        check("abort_ram_addr", {12'b0, ram_addr}, 32'd0);
        last_if = '0; last_mem = '0;
        run_txn("post_rst", vecs[0]);

        // WAIT=0: back-to-back fetches with req held high
        @(negedge clk);
        z_if_req = 1'b1; z_if_addr = 32'h40; z_ram_din = 32'hA1A1A1A1;
        exp_q.push_back(32'hA1A1A1A1);
        @(posedge clk);
        for (int k = 1; k < 12 && z_ack_q.size() < 2; k++) begin
            @(negedge clk);
            if (k == 1) check("w0_addr0", {12'b0, z_ram_addr}, 32'h10);
            if (k == 4) check("w0_addr1", {12'b0, z_ram_addr}, 32'h20);
            if (z_if_ack) begin
                z_ack_q.push_back(k);
                check("w0_rdata", z_if_rdata, pop_exp());
                if (z_ack_q.size() == 1) begin
                    z_if_addr = 32'h80; z_ram_din = 32'hB2B2B2B2;
                    exp_q.push_back(32'hB2B2B2B2);
                end else begin
                    z_if_req = 1'b0;
                end
            end
        end
        z_if_req = 1'b0;
        check("w0_ack_count", 32'(z_ack_q.size()), 32'd2);
        if (z_ack_q.size() == 2) begin
            check("w0_ack0_cycle", 32'(z_ack_q[0]), 32'd2);
            check("w0_ack1_cycle", 32'(z_ack_q[1]), 32'd5);
        end
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
